// File: rtl/bp_bht_update_ctrl.sv
// rtl/bp_bht_update_ctrl.sv - single-outstanding branch predict/update controller for the tournament BHT
//
// Purpose: accepts one branch-prediction request from fetch, reads the BHT,
// holds the in-flight prediction until the backend resolves it, then issues a
// one-cycle table update carrying the correct/incorrect verdict. Keeps
// saturating prediction and mispredict counters and a sticky error flag.
//
// Ports:
//   clk_i, reset_i                    clock, synchronous active-high reset
//   fe_req_v_i/pc_i/ready_o           fetch prediction request handshake
//   fe_pred_v_o, fe_pred_taken_o      prediction returned in the accept cycle
//   bht_r_o, bht_r_pc_o, bht_predict_i  table read port (combinational)
//   bht_w_o, bht_w_pc_o, bht_correct_o  table update port
//   be_res_v_i/pc_i/taken_i           backend resolution
//   flush_i                           drop the pending branch without update
//   mispredict_o                      pulse in an update cycle with a wrong guess
//   err_o                             sticky protocol error
//   pred_cnt_o, mispred_cnt_o         saturating statistics

module bp_bht_update_ctrl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             fe_req_v_i,
    input  logic [PC_W-1:0]  fe_req_pc_i,
    output logic             fe_req_ready_o,
    output logic             fe_pred_v_o,
    output logic             fe_pred_taken_o,
    output logic             bht_r_o,
    output logic [PC_W-1:0]  bht_r_pc_o,
    input  logic             bht_predict_i,
    output logic             bht_w_o,
    output logic [PC_W-1:0]  bht_w_pc_o,
    output logic             bht_correct_o,
    input  logic             be_res_v_i,
    input  logic [PC_W-1:0]  be_res_pc_i,
    input  logic             be_res_taken_i,
    input  logic             flush_i,
    output logic             mispredict_o,
    output logic             err_o,
    output logic [CNT_W-1:0] pred_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        UPD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q;
    logic              pred_q;
    logic              correct_q;
    logic              err_q;
    logic [CNT_W-1:0]  pred_cnt_q;
    logic [CNT_W-1:0]  mispred_cnt_q;

    logic              accept;
    logic              res_match;
    logic              err_set;

    always_comb begin
        state_d         = state_q;
        accept          = 1'b0;
        res_match       = 1'b0;
        err_set         = 1'b0;
        fe_req_ready_o  = 1'b0;
        fe_pred_v_o     = 1'b0;
        fe_pred_taken_o = 1'b0;
        bht_r_o         = 1'b0;
        bht_r_pc_o      = '0;
        bht_w_o         = 1'b0;
        bht_w_pc_o      = '0;
        bht_correct_o   = 1'b0;
        mispredict_o    = 1'b0;

        case (state_q)
            IDLE: begin
                fe_req_ready_o = ~flush_i;
                if (fe_req_v_i && !flush_i) begin
                    accept          = 1'b1;
                    bht_r_o         = 1'b1;
                    bht_r_pc_o      = fe_req_pc_i;
                    fe_pred_v_o     = 1'b1;
                    fe_pred_taken_o = bht_predict_i;
                    state_d         = PEND;
                end
                if (be_res_v_i) begin
                    err_set = 1'b1;
                end
            end
            PEND: begin
                // flush wins over a same-cycle resolve: the branch is dead
                if (flush_i) begin
                    state_d = IDLE;
                end else if (be_res_v_i) begin
                    if (be_res_pc_i == pc_q) begin
                        res_match = 1'b1;
                        state_d   = UPD;
                    end else begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            UPD: begin
                // resolution is committed, so flush_i is not consulted here
                bht_w_o       = 1'b1;
                bht_w_pc_o    = pc_q;
                bht_correct_o = correct_q;
                mispredict_o  = ~correct_q;
                if (be_res_v_i) begin
                    err_set = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // outputs are forced quiet for the whole reset cycle, whatever state we were in
        if (reset_i) begin
            fe_req_ready_o  = 1'b0;
            fe_pred_v_o     = 1'b0;
            fe_pred_taken_o = 1'b0;
            bht_r_o         = 1'b0;
            bht_r_pc_o      = '0;
            bht_w_o         = 1'b0;
            bht_w_pc_o      = '0;
            bht_correct_o   = 1'b0;
            mispredict_o    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            pred_q        <= 1'b0;
            correct_q     <= 1'b0;
            err_q         <= 1'b0;
            pred_cnt_q    <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pc_q   <= fe_req_pc_i;
                pred_q <= bht_predict_i;
                if (pred_cnt_q != '1) begin
                    pred_cnt_q <= pred_cnt_q + CNT_W'(1);
                end
            end
            if (res_match) begin
                correct_q <= (pred_q == be_res_taken_i);
            end
            if ((state_q == UPD) && !correct_q && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o         = err_q & ~reset_i;
    assign pred_cnt_o    = reset_i ? '0 : pred_cnt_q;
    assign mispred_cnt_o = reset_i ? '0 : mispred_cnt_q;

endmodule

// File: tb/tb_bp_bht_update_ctrl.sv
// tb/tb_bp_bht_update_ctrl.sv - directed self-checking bench for bp_bht_update_ctrl

module tb_bp_bht_update_ctrl;

    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             fe_req_v;
    logic [PC_W-1:0]  fe_req_pc;
    logic             fe_req_ready;
    logic             fe_pred_v;
    logic             fe_pred_taken;
    logic             bht_r;
    logic [PC_W-1:0]  bht_r_pc;
    logic             bht_predict;
    logic             bht_w;
    logic [PC_W-1:0]  bht_w_pc;
    logic             bht_correct;
    logic             be_res_v;
    logic [PC_W-1:0]  be_res_pc;
    logic             be_res_taken;
    logic             flush;
    logic             mispredict;
    logic             err;
    logic [CNT_W-1:0] pred_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bp_bht_update_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .fe_req_v_i      (fe_req_v),
        .fe_req_pc_i     (fe_req_pc),
        .fe_req_ready_o  (fe_req_ready),
        .fe_pred_v_o     (fe_pred_v),
        .fe_pred_taken_o (fe_pred_taken),
        .bht_r_o         (bht_r),
        .bht_r_pc_o      (bht_r_pc),
        .bht_predict_i   (bht_predict),
        .bht_w_o         (bht_w),
        .bht_w_pc_o      (bht_w_pc),
        .bht_correct_o   (bht_correct),
        .be_res_v_i      (be_res_v),
        .be_res_pc_i     (be_res_pc),
        .be_res_taken_i  (be_res_taken),
        .flush_i         (flush),
        .mispredict_o    (mispredict),
        .err_o           (err),
        .pred_cnt_o      (pred_cnt),
        .mispred_cnt_o   (mispred_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        fe_req_v     = 1'b0;
        fe_req_pc    = '0;
        bht_predict  = 1'b0;
        be_res_v     = 1'b0;
        be_res_pc    = '0;
        be_res_taken = 1'b0;
        flush        = 1'b0;
    endtask

    // advance one clock; inputs are driven and outputs sampled 1-2ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // accept / resolve / update, leaves the DUT in IDLE with inputs idle
    task automatic do_branch(input logic [PC_W-1:0] pc, input logic pred, input logic taken);
        fe_req_v = 1'b1; fe_req_pc = pc; bht_predict = pred;
        tick();
        clear_inputs();
        be_res_v = 1'b1; be_res_pc = pc; be_res_taken = taken;
        tick();
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        fe_req_v = 1'b1; fe_req_pc = 32'h40;
        tick();
        #1;
        check("rst_ready", fe_req_ready, 0);
        check("rst_pred_v", fe_pred_v, 0);
        check("rst_r", bht_r, 0);
        check("rst_cnt", pred_cnt, 0);
        check("rst_err", err, 0);
        tick();
        reset = 1'b0;
        clear_inputs();

        // correct not-taken prediction at 0x100
        fe_req_v = 1'b1; fe_req_pc = 32'h100; bht_predict = 1'b0;
        #1;
        check("t1_ready", fe_req_ready, 1);
        check("t1_pred_v", fe_pred_v, 1);
        check("t1_taken", fe_pred_taken, 0);
        check("t1_r", bht_r, 1);
        check("t1_r_pc", bht_r_pc, 32'h100);
        tick();
        clear_inputs();
        be_res_v = 1'b1; be_res_pc = 32'h100; be_res_taken = 1'b0;
        #1;
        check("t1_pend_ready", fe_req_ready, 0);
        check("t1_pred_cnt", pred_cnt, 1);
        check("t1_pend_w", bht_w, 0);
        tick();
        clear_inputs();
        #1;
        check("t1_w", bht_w, 1);
        check("t1_w_pc", bht_w_pc, 32'h100);
        check("t1_correct", bht_correct, 1);
        check("t1_mispred", mispredict, 0);
        check("t1_upd_r", bht_r, 0);
        tick();
        check("t1_mcnt", mispred_cnt, 0);
        check("t1_idle_w", bht_w, 0);
        check("t1_idle_ready", fe_req_ready, 1);

        // taken prediction at 0x204 resolved not-taken
        fe_req_v = 1'b1; fe_req_pc = 32'h204; bht_predict = 1'b1;
        #1;
        check("t2_taken", fe_pred_taken, 1);
        tick();
        clear_inputs();
        be_res_v = 1'b1; be_res_pc = 32'h204; be_res_taken = 1'b0;
        tick();
        clear_inputs();
        #1;
        check("t2_w", bht_w, 1);
        check("t2_correct", bht_correct, 0);
        check("t2_mispred", mispredict, 1);
        tick();
        check("t2_mispred_pulse", mispredict, 0);
        check("t2_mcnt", mispred_cnt, 1);
        check("t2_pcnt", pred_cnt, 2);

        // fetch held valid with resolves in every PEND cycle: accepts every 3 cycles
        for (int i = 0; i < 9; i++) begin
            fe_req_v     = 1'b1;
            fe_req_pc    = 32'h400 + 32'(4 * (i / 3));
            bht_predict  = 1'b0;
            be_res_v     = (i % 3 == 1);
            be_res_pc    = 32'h400 + 32'(4 * (i / 3));
            be_res_taken = 1'b0;
            #1;
            check($sformatf("t3_pred_v_%0d", i), fe_pred_v, (i % 3 == 0));
            check($sformatf("t3_w_%0d", i), bht_w, (i % 3 == 2));
            check($sformatf("t3_rw_%0d", i), bht_r & bht_w, 0);
            tick();
        end
        clear_inputs();
        #1;
        check("t3_pcnt", pred_cnt, 5);
        check("t3_mcnt", mispred_cnt, 1);
        // the 10th cycle would accept again; with fe_req_v low we are in IDLE
        check("t3_ready", fe_req_ready, 1);

        // flush while pending
        fe_req_v = 1'b1; fe_req_pc = 32'h500;
        tick();
        clear_inputs();
        flush = 1'b1;
        #1;
        check("t4_flush_ready", fe_req_ready, 0);
        tick();
        clear_inputs();
        #1;
        check("t4_flush_w", bht_w, 0);
        check("t4_flush_ready_idle", fe_req_ready, 1);
        check("t4_flush_err", err, 0);

        // flush and matching resolve together
        fe_req_v = 1'b1; fe_req_pc = 32'h504;
        tick();
        clear_inputs();
        flush = 1'b1; be_res_v = 1'b1; be_res_pc = 32'h504;
        tick();
        clear_inputs();
        #1;
        check("t4_fr_w", bht_w, 0);
        check("t4_fr_ready", fe_req_ready, 1);
        check("t4_fr_err", err, 0);

        // flush during the update cycle is ignored
        fe_req_v = 1'b1; fe_req_pc = 32'h508;
        tick();
        clear_inputs();
        be_res_v = 1'b1; be_res_pc = 32'h508;
        tick();
        clear_inputs();
        flush = 1'b1;
        #1;
        check("t4_upd_flush_w", bht_w, 1);
        check("t4_upd_flush_pc", bht_w_pc, 32'h508);
        tick();
        clear_inputs();
        check("t4_pcnt", pred_cnt, 8);

        // PC mismatch: 0x300 resolved while 0x304 pending
        fe_req_v = 1'b1; fe_req_pc = 32'h304;
        tick();
        clear_inputs();
        be_res_v = 1'b1; be_res_pc = 32'h300;
        #1;
        check("t5_mm_err_before", err, 0);
        tick();
        clear_inputs();
        #1;
        check("t5_mm_err", err, 1);
        check("t5_mm_w", bht_w, 0);
        check("t5_mm_ready", fe_req_ready, 1);
        tick();
        check("t5_mm_sticky", err, 1);

        // reset clears err, then a resolve in IDLE raises it
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("t5_rst_err", err, 0);
        check("t5_rst_pcnt", pred_cnt, 0);
        be_res_v = 1'b1; be_res_pc = 32'h700;
        tick();
        clear_inputs();
        #1;
        check("t5_idle_err", err, 1);
        check("t5_idle_w", bht_w, 0);
        check("t5_idle_ready", fe_req_ready, 1);
        tick();
        tick();
        check("t5_idle_sticky", err, 1);

        // saturation: 20 mispredicted branches on a 4-bit counter
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            do_branch(32'h800 + 32'(4 * i), 1'b1, 1'b0);
        end
        #1;
        check("t6_pcnt_sat", pred_cnt, 15);
        check("t6_mcnt_sat", mispred_cnt, 15);
        check("t6_err", err, 0);

        // reset while pending
        fe_req_v = 1'b1; fe_req_pc = 32'h900;
        tick();
        clear_inputs();
        reset = 1'b1;
        be_res_v = 1'b1; be_res_pc = 32'h900;
        #1;
        check("t6_rst_ready", fe_req_ready, 0);
        check("t6_rst_w", bht_w, 0);
        check("t6_rst_pcnt", pred_cnt, 0);
        check("t6_rst_mcnt", mispred_cnt, 0);
        check("t6_rst_err", err, 0);
        tick();
        clear_inputs();
        reset = 1'b0;
        fe_req_v = 1'b1; fe_req_pc = 32'hA00;
        #1;
        check("t6_post_w", bht_w, 0);
        check("t6_post_pred_v", fe_pred_v, 1);
        check("t6_post_r_pc", bht_r_pc, 32'hA00);
        tick();
        clear_inputs();
        #1;
        check("t6_post_pcnt", pred_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bp_bht_update_ctrl.md
# bp_bht_update_ctrl

Front-end controller that drives the read and update ports of the tournament branch history table. It accepts branch-prediction requests from fetch and issues the table read, returning the direction. It holds the single in-flight prediction, matches it against the backend resolution, and issues the one-cycle table update with the correct/incorrect verdict. The table keeps only one pending prediction, so this block enforces exactly one outstanding branch. It also keeps prediction and mispredict statistics.

## Interface
- PC_W, 32, PC width; must equal the table's PC_W.
- CNT_W, 32, statistics counter width.

- clk_i  in  1  clock; all state changes on rising edge.
- reset_i  in  1  reset; synchronous, active high.
- fe_req_v_i  in  1  fetch requests a prediction for a branch.
- fe_req_pc_i  in  PC_W  branch PC.
- fe_req_ready_o  out  1  request accepted when fe_req_v_i & fe_req_ready_o.
- fe_pred_v_o  out  1  prediction valid; high in the accept cycle only.
- fe_pred_taken_o  out  1  predicted direction, equal to bht_predict_i in the accept cycle, else 0.
- bht_r_o  out  1  table read enable.
- bht_r_pc_o  out  PC_W  table read address.
- bht_predict_i  in  1  table prediction, combinational from bht_r_pc_o.
- bht_w_o  out  1  table update enable.
- bht_w_pc_o  out  PC_W  table update address.
- bht_correct_o  out  1  1 means the held prediction matched the actual outcome.
- be_res_v_i  in  1  backend resolves a branch.
- be_res_pc_i  in  PC_W  resolved branch PC.
- be_res_taken_i  in  1  actual direction.
- flush_i  in  1  kill any pending branch without updating the table.
- mispredict_o  out  1  one-cycle pulse in the update cycle when bht_correct_o = 0.
- err_o  out  1  sticky: PC-mismatched resolve, or resolve with nothing pending.
- pred_cnt_o  out  CNT_W  accepted predictions, saturating.
- mispred_cnt_o  out  CNT_W  mispredicted updates, saturating.

## Operation
- States: IDLE, PEND, UPD. Reset enters IDLE. While reset_i is high, all outputs are 0, counters clear, err_o clears and held registers clear.
- **IDLE**
  - fe_req_ready_o = ~flush_i.
  - On accept: bht_r_o = 1, bht_r_pc_o = fe_req_pc_i, fe_pred_v_o = 1, fe_pred_taken_o = bht_predict_i.
  - Latch pc_q and pred_q, increment pred_cnt_o, and go to PEND.
  - Otherwise bht_r_o = 0 and bht_r_pc_o = 0.
- **PEND**
  - fe_req_ready_o = 0.
  - flush_i has priority: go to IDLE with no update and no error.
  - On be_res_v_i with be_res_pc_i == pc_q: latch correct_q = (pred_q == be_res_taken_i) and go to UPD.
  - On be_res_v_i with a PC mismatch: set err_o, go to IDLE, no update.
- **UPD** (exactly one cycle)
  - Drive bht_w_o = 1, bht_w_pc_o = pc_q, bht_correct_o = correct_q, mispredict_o = ~correct_q.
  - Increment mispred_cnt_o if ~correct_q.
  - fe_req_ready_o = 0. flush_i is ignored, because the resolution is already committed.
  - Next state is IDLE.
- bht_w_pc_o and bht_correct_o are 0 outside UPD.
- A be_res_v_i in IDLE or UPD sets err_o and has no other effect.
- Counters saturate at all ones and never wrap.
- Never assert bht_r_o and bht_w_o in the same cycle, because the table would read stale contents.

## Timing
- Prediction latency is 0 cycles: fe_pred_taken_o is valid in the accept cycle T.
- The earliest resolution is T+1. The update fires in the cycle after the resolve cycle R, i.e. R+1. The next accept is possible at R+2.
- Minimum issue interval is 3 cycles per branch (accept, resolve, update).
- err_o rises in the cycle after the offending resolve and stays high until reset.
- Counter values are visible in the cycle after the event.
- Reset asserted mid-PEND or mid-UPD: no update is issued, and the first accept is possible in the first cycle after reset_i drops.

## Test plan
- Reset, then request PC 0x100 with bht_predict_i = 0, then resolve PC 0x100 not-taken -> accept cycle shows fe_pred_v_o = 1, fe_pred_taken_o = 0. Next cycle bht_w_o = 1, bht_w_pc_o = 0x100, bht_correct_o = 1, mispredict_o = 0. pred_cnt_o = 1, mispred_cnt_o = 0.
- Predict taken at 0x204, resolve not-taken -> bht_correct_o = 0, mispredict_o pulses for 1 cycle, mispred_cnt_o = 1.
- Hold fe_req_v_i high continuously with back-to-back resolves -> accepts occur every 3 cycles, and bht_r_o and bht_w_o are never high together.
- Flush in PEND, and separately flush and resolve in the same PEND cycle -> no bht_w_o, state returns to IDLE, err_o = 0. A flush in the UPD cycle still leaves bht_w_o = 1.
- Resolve PC 0x300 while 0x304 is pending, and a resolve in IDLE -> err_o = 1 and sticky, no update issued, fe_req_ready_o = 1 the following cycle.
- Preload the counters near all ones (CNT_W = 4, 20 predictions) -> pred_cnt_o holds at 15. Assert reset_i while in PEND -> all outputs 0 and no bht_w_o.
